// File: rtl/tcdm_master_buf.sv
// Elastic request buffer in front of one butterfly-network master port.
// Core requests are queued in a small circular FIFO; network responses are registered once.
module tcdm_master_buf #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  // core side
  input  logic                       req_i,
  output logic                       gnt_o,
  input  logic [AddrWidth-1:0]       add_i,
  input  logic                       wen_i,
  input  logic [DataWidth-1:0]       data_i,
  output logic [DataWidth-1:0]       rdata_o,
  output logic                       vld_o,
  // network side
  output logic                       req_o,
  input  logic                       gnt_i,
  output logic [AddrWidth-1:0]       add_o,
  output logic                       wen_o,
  output logic [DataWidth-1:0]       data_o,
  input  logic [DataWidth-1:0]       rdata_i,
  input  logic                       vld_i,
  output logic [$clog2(Depth):0]     usage_o
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned UsageWidth = PtrWidth + 1;

  logic [AddrWidth-1:0]  add_mem  [Depth];
  logic                  wen_mem  [Depth];
  logic [DataWidth-1:0]  data_mem [Depth];

  logic [PtrWidth-1:0]   rd_ptr, wr_ptr;
  logic [UsageWidth-1:0] usage;
  logic                  push, pop;

  // Flow control depends on registered occupancy only, so gnt_i never reaches gnt_o.
  assign gnt_o   = (usage != UsageWidth'(Depth));
  assign req_o   = (usage != '0);
  assign push    = req_i & gnt_o;
  assign pop     = req_o & gnt_i;
  assign usage_o = usage;

  assign add_o  = add_mem[rd_ptr];
  assign wen_o  = wen_mem[rd_ptr];
  assign data_o = data_mem[rd_ptr];

  // Storage carries no reset: head contents are only meaningful while req_o is high.
  always_ff @(posedge clk_i) begin
    if (push) begin
      add_mem[wr_ptr]  <= add_i;
      wen_mem[wr_ptr]  <= wen_i;
      data_mem[wr_ptr] <= data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      usage  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   usage <= usage + 1'b1;
        2'b01:   usage <= usage - 1'b1;
        default: usage <= usage;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      vld_o <= vld_i;
      if (vld_i) rdata_o <= rdata_i;
    end
  end

endmodule

// File: tb/tb_tcdm_master_buf.sv
// Directed bench for tcdm_master_buf (Depth=2): vector table plus multi-cycle corner sequences.
module tb_tcdm_master_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, gnt_o, wen_i, vld_o, req_o, gnt_i, wen_o, vld_i;
  logic [4:0]  add_i, add_o;
  logic [31:0] data_i, rdata_o, data_o, rdata_i;
  logic [1:0]  usage_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tcdm_master_buf #(.AddrWidth(5), .DataWidth(32), .Depth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i), .data_i(data_i),
    .rdata_o(rdata_o), .vld_o(vld_o),
    .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .wen_o(wen_o), .data_o(data_o),
    .rdata_i(rdata_i), .vld_i(vld_i), .usage_o(usage_o)
  );

  typedef struct {
    logic        req;  logic [4:0] add; logic wen; logic [31:0] data;
    logic        gnt;  logic vld;       logic [31:0] rdata;
    logic [1:0]  e_usage; logic e_req; logic e_gnt;
    logic [4:0]  e_add;   logic e_wen; logic [31:0] e_data;
    logic        e_vld;   logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [4:0] add, input logic wen,
                       input logic [31:0] data, input logic gnt, input logic vld,
                       input logic [31:0] rdata);
    req_i = req; add_i = add; wen_i = wen; data_i = data;
    gnt_i = gnt; vld_i = vld; rdata_i = rdata;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // expected columns describe the outputs just after the edge that consumed the inputs
    //          req  add    wen   data       gnt   vld   rdata          usage req   gnt   add    wen   data       vld   rdata
    vecs[0]  = '{1'b1, 5'h03, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 5'h03, 1'b0, 32'h0,     1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'h00, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         2'd0, 1'b0, 1'b1, 5'h00, 1'b0, 32'h0,     1'b0, 32'h0};
    vecs[2]  = '{1'b0, 5'h00, 1'b0, 32'h0,     1'b0, 1'b1, 32'hCAFE0001,  2'd0, 1'b0, 1'b1, 5'h00, 1'b0, 32'h0,     1'b1, 32'hCAFE0001};
    vecs[3]  = '{1'b0, 5'h00, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b1, 5'h00, 1'b0, 32'h0,     1'b0, 32'hCAFE0001};
    vecs[4]  = '{1'b1, 5'h01, 1'b1, 32'hA,     1'b0, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 5'h01, 1'b1, 32'hA,     1'b0, 32'hCAFE0001};
    vecs[5]  = '{1'b1, 5'h02, 1'b1, 32'hB,     1'b0, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 5'h01, 1'b1, 32'hA,     1'b0, 32'hCAFE0001};
    vecs[6]  = '{1'b1, 5'h04, 1'b0, 32'hC,     1'b0, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 5'h01, 1'b1, 32'hA,     1'b0, 32'hCAFE0001};
    vecs[7]  = '{1'b1, 5'h05, 1'b0, 32'hD,     1'b1, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 5'h02, 1'b1, 32'hB,     1'b0, 32'hCAFE0001};
    vecs[8]  = '{1'b0, 5'h00, 1'b0, 32'h0,     1'b0, 1'b1, 32'h11111111,  2'd1, 1'b1, 1'b1, 5'h02, 1'b1, 32'hB,     1'b1, 32'h11111111};
    vecs[9]  = '{1'b0, 5'h00, 1'b0, 32'h0,     1'b1, 1'b1, 32'h22222222,  2'd0, 1'b0, 1'b1, 5'h00, 1'b0, 32'h0,     1'b1, 32'h22222222};
    vecs[10] = '{1'b0, 5'h00, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b1, 5'h00, 1'b0, 32'h0,     1'b0, 32'h22222222};

    rst_n = 1'b0;
    drive(1'b0, 5'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("reset_usage", 32'(usage_o), 32'd0);
    chk("reset_req_o", 32'(req_o),   32'd0);
    chk("reset_gnt_o", 32'(gnt_o),   32'd1);
    chk("reset_vld_o", 32'(vld_o),   32'd0);
    chk("reset_rdata", rdata_o,      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single read, fill/stall, full-with-pop, back-to-back responses
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].add, vecs[i].wen, vecs[i].data,
            vecs[i].gnt, vecs[i].vld, vecs[i].rdata);
      cycle();
      chk($sformatf("v%0d_usage", i), 32'(usage_o), 32'(vecs[i].e_usage));
      chk($sformatf("v%0d_req_o", i), 32'(req_o),   32'(vecs[i].e_req));
      chk($sformatf("v%0d_gnt_o", i), 32'(gnt_o),   32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_vld_o", i), 32'(vld_o),   32'(vecs[i].e_vld));
      chk($sformatf("v%0d_rdata", i), rdata_o,      vecs[i].e_rdata);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_add_o", i),  32'(add_o), 32'(vecs[i].e_add));
        chk($sformatf("v%0d_wen_o", i),  32'(wen_o), 32'(vecs[i].e_wen));
        chk($sformatf("v%0d_data_o", i), data_o,     vecs[i].e_data);
      end
    end

    // wrap-around: 7 back-to-back writes with continuous grant
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 1'b1, 32'(i), 1'b1, 1'b0, 32'h0);
      cycle();
      chk($sformatf("wrap%0d_usage", i), 32'(usage_o), 32'd1);
      chk($sformatf("wrap%0d_data", i),  data_o,       32'(i));
      chk($sformatf("wrap%0d_add", i),   32'(add_o),   32'(i));
    end
    @(negedge clk);
    drive(1'b0, 5'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    chk("wrap_drain_usage", 32'(usage_o), 32'd0);

    // sustained push+pop at occupancy 1 keeps order
    @(negedge clk);
    drive(1'b1, 5'h1F, 1'b0, 32'd100, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("pp_preload_usage", 32'(usage_o), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("pp%0d_head", k), data_o, 32'(100 + k));
      drive(1'b1, 5'h1F, 1'b0, 32'(101 + k), 1'b1, 1'b0, 32'h0);
      cycle();
      chk($sformatf("pp%0d_usage", k), 32'(usage_o), 32'd1);
    end
    @(negedge clk);
    chk("pp_last_head", data_o, 32'd110);
    drive(1'b0, 5'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    chk("pp_drain_usage", 32'(usage_o), 32'd0);

    // reset mid-flight with full FIFO and a response in capture
    @(negedge clk);
    drive(1'b1, 5'h06, 1'b1, 32'hE0, 1'b0, 1'b0, 32'h0);
    cycle();
    @(negedge clk);
    drive(1'b1, 5'h07, 1'b1, 32'hE1, 1'b0, 1'b1, 32'hDEAD0000);
    cycle();
    chk("pre_rst_usage", 32'(usage_o), 32'd2);
    chk("pre_rst_vld",   32'(vld_o),   32'd1);
    @(negedge clk);
    drive(1'b1, 5'h08, 1'b1, 32'hE2, 1'b1, 1'b1, 32'hDEAD0001);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_usage", 32'(usage_o), 32'd0);
    chk("rst_async_req_o", 32'(req_o),   32'd0);
    chk("rst_async_gnt_o", 32'(gnt_o),   32'd1);
    chk("rst_async_vld_o", 32'(vld_o),   32'd0);
    chk("rst_async_rdata", rdata_o,      32'h0);
    cycle();
    chk("rst_hold_vld_o",  32'(vld_o),   32'd0);
    chk("rst_hold_usage",  32'(usage_o), 32'd0);
    @(negedge clk);
    drive(1'b0, 5'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("post_rst%0d_req_o", k), 32'(req_o),   32'd0);
      chk($sformatf("post_rst%0d_vld_o", k), 32'(vld_o),   32'd0);
      chk($sformatf("post_rst%0d_usage", k), 32'(usage_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
